// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//   Shares one external WIDTH-bit adder (carry-in tied 0) among NREQ
//   requesters. A round-robin search picks one valid requester per operation.
//   Its operands are registered onto add_a/add_b. The adder's sum/carry are
//   captured one cycle later. The result is then held on rsp_* until the
//   consumer takes it.
//
//   Operation sequence: IDLE (accept) -> ADD (adder settles) -> RESP (hold).
//   This takes at least 3 cycles per operation.
//
// Parameters
//   WIDTH      operand / sum width (must match the adder instance)
//   NREQ       number of requesters, 2..8
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  per-requester operand-pair valid
//   req_ready  one-hot accept strobe (combinational, IDLE only)
//   req_a/b    packed operands, requester i at [i*WIDTH +: WIDTH]
//   add_a/b    registered operands to the shared adder
//   add_sum    adder sum (combinational from add_a/add_b)
//   add_carry  adder carry-out
//   rsp_valid  result available
//   rsp_ready  consumer takes result
//   rsp_id     index of requester owning the result
//   rsp_sum    captured sum
//   rsp_carry  captured carry-out
//   ovf_count  (only with ADDARB_OVF_CNT_EN) saturating count of ADD cycles
//              that saw add_carry=1
//
// Optional feature macro: ADDARB_OVF_CNT_EN
// ---------------------------------------------------------------------------
module adder_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*WIDTH-1:0]         req_a,
    input  logic [NREQ*WIDTH-1:0]         req_b,
    output logic [WIDTH-1:0]              add_a,
    output logic [WIDTH-1:0]              add_b,
    input  logic [WIDTH-1:0]              add_sum,
    input  logic                          add_carry,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic [WIDTH-1:0]              rsp_sum,
`ifdef ADDARB_OVF_CNT_EN
    output logic                          rsp_carry,
    output logic [7:0]                    ovf_count
`else
    output logic                          rsp_carry
`endif
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_carry_q, rsp_carry_d;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;

    // Round-robin search: the first valid index after the last grant, wrapping.
    // Offset NREQ lands back on ptr itself, so a lone requester can win again.
    always_comb begin
        logic [IDW-1:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // Next-state and outputs
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        req_ready   = '0;

        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    // Suppress the accept strobe while reset is asserted. The
                    // registers will not take the pair in that cycle.
                    req_ready = rst ? '0 : (NREQ'(1) << gnt_idx);
                    add_a_d   = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                    add_b_d   = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                    rsp_id_d  = gnt_idx;
                    ptr_d     = gnt_idx;
                    state_d   = S_ADD;
                end
            end
            S_ADD: begin
                rsp_sum_d   = add_sum;
                rsp_carry_d = add_carry;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

`ifdef ADDARB_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating count of additions that produced a carry-out
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (state_q == S_ADD && add_carry && ovf_cnt_q != 8'hFF) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`endif

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;

endmodule
